// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] ps_q, ps_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;

   logic             bit_s;
   logic             bit_c;
   logic [WIDTH-1:0] ps_shift;

   always_comb begin
      bit_s    = sa_q[0] ^ sb_q[0] ^ c_q;
      bit_c    = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
      // New bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
      ps_shift = (ps_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ps_d    = ps_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               c_d     = cin;
               cnt_d   = '0;
               ps_d    = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            c_d   = bit_c;
            ps_d  = ps_shift;
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               sum_d   = ps_shift;
               cout_d  = bit_c;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ps_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ps_q    <= ps_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks of serial_add_ctrl at WIDTH 8, 1 and 5
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic [7:0] a_r, b_r;
   logic       cin_r;

   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;
   logic       busy5, done5, cout5;
   logic [4:0] sum5;

   int errors = 0;
   int checks = 0;

   // per-instance model state: 0 = WIDTH 8, 1 = WIDTH 1, 2 = WIDTH 5
   int         widths [3] = '{8, 1, 5};
   logic [7:0] last_sum [3];
   logic       last_cout [3];
   logic [1:0] sel;

   logic       busy_m, done_m, cout_m;
   logic [7:0] sum_m;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a_r), .b(b_r), .cin(cin_r),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a_r[0:0]), .b(b_r[0:0]), .cin(cin_r),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   serial_add_ctrl #(.WIDTH(5)) u_w5 (
      .clk(clk), .rst(rst), .start(start_v[2]), .a(a_r[4:0]), .b(b_r[4:0]), .cin(cin_r),
      .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
   );

   always_comb begin
      busy_m = busy8;
      done_m = done8;
      cout_m = cout8;
      sum_m  = sum8;
      case (sel)
         2'd1: begin busy_m = busy1; done_m = done1; cout_m = cout1; sum_m = {7'b0, sum1}; end
         2'd2: begin busy_m = busy5; done_m = done5; cout_m = cout5; sum_m = {3'b0, sum5}; end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 3; i++) begin
         last_sum[i]  = 8'h00;
         last_cout[i] = 1'b0;
      end
   endtask

   // One start pulse on instance s; operands are scrambled right after the accepting edge.
   task automatic do_op(input logic [1:0] s, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input string tag);
      int         w;
      logic [8:0] mask;
      logic [8:0] full;
      logic [7:0] exp_sum;
      logic       exp_cout;
      w        = widths[s];
      mask     = (9'd1 << w) - 9'd1;
      full     = {1'b0, ta} & mask;
      full     = full + ({1'b0, tb_v} & mask) + {8'b0, tc};
      exp_sum  = full[7:0] & mask[7:0];
      exp_cout = full[w];
      sel      = s;
      a_r      = ta;
      b_r      = tb_v;
      cin_r    = tc;
      start_v[s] = 1'b1;
      @(negedge clk);
      start_v[s] = 1'b0;
      a_r   = ~ta;
      b_r   = ~tb_v;
      cin_r = ~tc;
      for (int i = 0; i < w; i++) begin
         check({tag, " busy"}, 32'(busy_m), 32'd1);
         check({tag, " done_early"}, 32'(done_m), 32'd0);
         check({tag, " sum_hold"}, 32'(sum_m), 32'(last_sum[s]));
         check({tag, " cout_hold"}, 32'(cout_m), 32'(last_cout[s]));
         @(negedge clk);
      end
      check({tag, " done"}, 32'(done_m), 32'd1);
      check({tag, " busy_off"}, 32'(busy_m), 32'd0);
      check({tag, " sum"}, 32'(sum_m), 32'(exp_sum));
      check({tag, " cout"}, 32'(cout_m), 32'(exp_cout));
      last_sum[s]  = exp_sum;
      last_cout[s] = exp_cout;
      @(negedge clk);
      check({tag, " done_width"}, 32'(done_m), 32'd0);
      check({tag, " idle_busy"}, 32'(busy_m), 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      start_v = 3'b000;
      a_r     = 8'h00;
      b_r     = 8'h00;
      cin_r   = 1'b0;
      sel     = 2'd0;
      clear_model();
      repeat (2) @(negedge clk);
      check("rst busy8", 32'(busy8), 32'd0);
      check("rst done8", 32'(done8), 32'd0);
      check("rst sum8", 32'(sum8), 32'd0);
      check("rst cout8", 32'(cout8), 32'd0);
      check("rst busy1", 32'(busy1), 32'd0);
      check("rst busy5", 32'(busy5), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_op(2'd0, 8'h5A, 8'h3C, 1'b0, "w8 5a+3c");
      do_op(2'd0, 8'hFF, 8'h01, 1'b0, "w8 ff+01");
      do_op(2'd0, 8'hFF, 8'hFF, 1'b1, "w8 ff+ff+1");

      // Continuous start: second accept at E10, operands sampled only on accepting edges.
      sel        = 2'd0;
      a_r        = 8'h11;
      b_r        = 8'h22;
      cin_r      = 1'b0;
      start_v[0] = 1'b1;
      for (int j = 1; j <= 21; j++) begin
         @(negedge clk);
         if (j == 1) begin a_r = 8'h40; b_r = 8'h05; cin_r = 1'b0; end
         if (j == 11) begin a_r = 8'hFF; b_r = 8'hFF; cin_r = 1'b1; end
         if (j == 19) start_v[0] = 1'b0;
         check("hold busy", 32'(busy8), ((j >= 1 && j <= 8) || (j >= 11 && j <= 18)) ? 32'd1 : 32'd0);
         check("hold done", 32'(done8), (j == 9 || j == 19) ? 32'd1 : 32'd0);
         if (j == 9) begin
            check("hold sum1", 32'(sum8), 32'h33);
            check("hold cout1", 32'(cout8), 32'd0);
         end
         if (j == 19) begin
            check("hold sum2", 32'(sum8), 32'h45);
            check("hold cout2", 32'(cout8), 32'd0);
         end
      end
      last_sum[0]  = 8'h45;
      last_cout[0] = 1'b0;

      // Reset in the 4th RUN cycle abandons the add.
      a_r        = 8'h12;
      b_r        = 8'h34;
      cin_r      = 1'b0;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("mid busy", 32'(busy8), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid rst busy", 32'(busy8), 32'd0);
      check("mid rst done", 32'(done8), 32'd0);
      check("mid rst sum", 32'(sum8), 32'd0);
      check("mid rst cout", 32'(cout8), 32'd0);
      clear_model();
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         check("mid no_done", 32'(done8), 32'd0);
      end
      do_op(2'd0, 8'h12, 8'h34, 1'b0, "w8 12+34");

      // WIDTH=1 full-adder truth table.
      for (int k = 0; k < 8; k++) begin
         logic [2:0] v;
         v = 3'(k);
         do_op(2'd1, {7'b0, v[2]}, {7'b0, v[1]}, v[0], "w1 fa");
      end

      for (int n = 0; n < 1000; n++)
         do_op(2'd0, 8'($urandom), 8'($urandom), 1'($urandom), "w8 rnd");
      for (int n = 0; n < 1000; n++)
         do_op(2'd2, 8'($urandom), 8'($urandom), 1'($urandom), "w5 rnd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
